// File: rtl/gate_bist_ctrl.sv
// ============================================================================
// Module   : gate_bist_ctrl
// Purpose  : Clocked stimulus/compare wrapper for a 2-input AND gate. Steps
//            {a,b} through 00,01,10,11, holds each vector HOLD_CYCLES cycles,
//            samples the gate output and reports per-vector failures, a
//            saturating error count and an overall pass flag.
// Options  : GATE_BIST_LOOP_EN - adds loop_en input; back-to-back passes with
//            accumulating err_count/fail_vec while loop_en is high.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gate_bist_ctrl #(
  parameter int HOLD_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef GATE_BIST_LOOP_EN
  input  logic             loop_en,
`endif
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic [1:0]       vec_idx
);

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        vec_q, vec_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [3:0]        fail_q, fail_d;

  logic              mismatch;
  logic [CNT_W-1:0]  err_inc;

  // Next-state and next-output computation; every output is registered so
  // the gate inputs change cleanly on the clock edge.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    // Case-equality so an X/Z on the gate output is reported as a failure.
    mismatch = (dut_y !== (a_q & b_q));
    err_inc  = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_APPLY;
          vec_d   = 2'd0;
          hold_d  = '0;
          err_d   = '0;
          fail_d  = 4'b0000;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_APPLY: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          vec_d  = vec_q + 2'd1;
          if (mismatch) begin
            err_d         = err_inc;
            fail_d[vec_q] = 1'b1;
          end
          if (vec_q == 2'd3) begin
            // Verdict includes a mismatch found on this very sample.
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (err_d == '0);
          end else begin
            {a_d, b_d} = vec_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
`ifdef GATE_BIST_LOOP_EN
        // Looping keeps err/fail so results accumulate over passes.
        if (loop_en) begin
          state_d = S_APPLY;
          vec_d   = 2'd0;
          hold_d  = '0;
          busy_d  = 1'b1;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      vec_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign vec_idx   = vec_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
// ============================================================================
// Module   : tb_gate_bist_ctrl
// Purpose  : Scoreboard bench for gate_bist_ctrl. A fault mask (one bit per
//            {a,b} vector) perturbs a modelled AND gate; the expected verdict
//            of each pass is derived from the mask and queued, and a monitor
//            compares it when done pulses.
// Options  : GATE_BIST_LOOP_EN - also exercises looped passes with CNT_W=3.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gate_bist_ctrl;

  localparam int HOLD = 5;
`ifdef GATE_BIST_LOOP_EN
  localparam int CW = 3;
`else
  localparam int CW = 8;
`endif
  localparam int MAXE = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          loop_en = 1'b0;
  logic          dut_y;
  logic          dut_a, dut_b, busy, done, pass;
  logic [CW-1:0] err_count;
  logic [3:0]    fail_vec;
  logic [1:0]    vec_idx;
  logic [3:0]    fault_mask = 4'b0000;

  // Modelled gate: a&b, inverted on the vectors selected by fault_mask.
  assign dut_y = (dut_a & dut_b) ^ fault_mask[{dut_a, dut_b}];

  gate_bist_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef GATE_BIST_LOOP_EN
    .loop_en   (loop_en),
`endif
    .dut_y     (dut_y),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .vec_idx   (vec_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         err;
    logic [3:0] fv;
    logic       ps;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [3:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
  endfunction

  function automatic int sat(input int x);
    return (x > MAXE) ? MAXE : x;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("done_cycle", cyc, m_e.at);
        chk("err_count", err_count, m_e.err);
        chk("fail_vec", fail_vec, m_e.fv);
        chk("pass", pass, m_e.ps);
        chk("done_busy_ab", {busy, dut_a, dut_b}, 3'b000);
      end
    end
  end

  // One single pass from IDLE; optionally pokes start mid-run.
  task automatic run_pass(input logic [3:0] mask, input bit poke_start);
    bit seq_ok;
    int ev;
    fault_mask = mask;
    @(negedge clk);
    start = 1'b1;
    sb.push_back('{err: sat(popc(mask)), fv: mask, ps: (mask == 4'b0000), at: cyc + 1 + 4*HOLD});
    seq_ok = 1'b1;
    for (int k = 1; k <= 4*HOLD; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk("clear_on_start", {err_count, fail_vec, pass}, '0);
      end
      if (poke_start && k == 7) start = 1'b1;
      if (poke_start && k == 8) start = 1'b0;
      ev = (k - 1) / HOLD;
      if ({dut_a, dut_b} != 2'(ev) || vec_idx != 2'(ev) || busy !== 1'b1 || done !== 1'b0)
        seq_ok = 1'b0;
    end
    chk("apply_seq", seq_ok, 1);
    @(negedge clk);
    #1;
    chk("done_seen", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("pass_hold", {pass, busy}, {(mask == 4'b0000), 1'b0});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [3:0] m;
    int         c;
    bit         ok;

    // Reset behaviour with the clock running.
    repeat (3) @(negedge clk);
    chk("rst_ab", {dut_a, dut_b}, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fail", fail_vec, 0);
    chk("rst_vec", vec_idx, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {busy, done, dut_a, dut_b}, 4'b0000);

    // Directed: good gate, stuck-at-1 (with ignored start), stuck-at-0.
    run_pass(4'b0000, 1'b0);
    run_pass(4'b0111, 1'b1);
    run_pass(4'b1000, 1'b0);

    // Randomized fault patterns.
    repeat (8) begin
      m = 4'($urandom_range(0, 15));
      run_pass(m, 1'($urandom_range(0, 1)));
    end

    // start held high: re-trigger one idle cycle after done.
    m = 4'($urandom_range(0, 15));
    fault_mask = m;
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    sb.push_back('{err: sat(popc(m)), fv: m, ps: (m == 4'b0000), at: c + 1 + 4*HOLD});
    sb.push_back('{err: sat(popc(m)), fv: m, ps: (m == 4'b0000), at: c + 1 + 4*HOLD + 2 + 4*HOLD});
    for (int i = 0; i < 12*HOLD + 20; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 1 && busy) start = 1'b0;
      if (sb.size() == 0) break;
    end
    start = 1'b0;
    chk("held_start_done", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);

    // Reset in the middle of a run: abandoned, no done, back to IDLE.
    fault_mask = 4'b0000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4*HOLD; i++) begin
      if (vec_idx == 2'd2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_vec2", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {dut_a, dut_b, busy, done, pass, err_count, fail_vec, vec_idx}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (4*HOLD + 5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    chk("idle_after_abort", ok, 1);
    run_pass(4'b0000, 1'b0);

`ifdef GATE_BIST_LOOP_EN
    // Looped stuck-at-1: three passes, error count saturating at 7.
    fault_mask = 4'b0111;
    loop_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    for (int p = 1; p <= 3; p++)
      sb.push_back('{err: sat(3*p), fv: 4'b0111, ps: 1'b0, at: c + p*(1 + 4*HOLD)});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16*HOLD + 20; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 1 && busy) loop_en = 1'b0;
      if (sb.size() == 0) break;
    end
    loop_en = 1'b0;
    chk("loop_all_done", sb.size(), 0);
    sb.delete();
    ok = 1'b1;
    repeat (4*HOLD + 5) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 1'b0;
    end
    chk("loop_exit_idle", ok, 1);
    chk("loop_sat_hold", err_count, MAXE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
